// File: rtl/fire_alarm_siren_ctrl_if.sv
// -----------------------------------------------------------------------------
// fire_alarm_siren_ctrl_if
//
// Groups the alarm request/control inputs and the siren/strobe/status outputs
// of fire_alarm_siren_ctrl into one bundle. clk and rst are kept as plain ports
// on the modules that use this interface.
//
// Signals:
//   alarmEnable    alarm request from the fire_alarm decode stage
//   silence        user hush button (level, already debounced)
//   test           siren self-test request
//   siren          siren drive, beep-patterned
//   strobe         visual strobe drive, steady while the alarm is latched
//   state          FSM state: 0 IDLE, 1 ALARM, 2 HUSH, 3 CLEAR_WAIT
//   alarm_latched  high whenever state != IDLE
//   hush_active    high in HUSH
//
// Modports:
//   master  the side that requests alarms and reads the siren/status
//   slave   the siren controller itself
// -----------------------------------------------------------------------------
interface fire_alarm_siren_ctrl_if;

   logic       alarmEnable;
   logic       silence;
   logic       test;
   logic       siren;
   logic       strobe;
   logic [1:0] state;
   logic       alarm_latched;
   logic       hush_active;

   modport master (
      output alarmEnable,
      output silence,
      output test,
      input  siren,
      input  strobe,
      input  state,
      input  alarm_latched,
      input  hush_active
   );

   modport slave (
      input  alarmEnable,
      input  silence,
      input  test,
      output siren,
      output strobe,
      output state,
      output alarm_latched,
      output hush_active
   );

endinterface : fire_alarm_siren_ctrl_if

// File: rtl/fire_alarm_siren_ctrl.sv
// -----------------------------------------------------------------------------
// fire_alarm_siren_ctrl
//
// First clocked stage of the alarm path. Latches an alarm request, drives a
// periodic beep on the siren and a steady strobe, supports a timed user hush,
// and only releases the alarm after alarmEnable has been low for CLEAR_CYCLES
// consecutive samples.
//
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous, active-high reset
//   bus  fire_alarm_siren_ctrl_if.slave
//          in : alarmEnable, silence, test
//          out: siren, strobe, state, alarm_latched, hush_active
//
// Every output is a flop. Each edge computes the complete next register image
// (outputs included) from the inputs sampled at that edge, so a decision taken
// at edge k is visible on the outputs right after edge k.
// -----------------------------------------------------------------------------
module fire_alarm_siren_ctrl #(
   parameter int unsigned BEEP_ON      = 4,
   parameter int unsigned BEEP_OFF     = 4,
   parameter int unsigned HUSH_CYCLES  = 32,
   parameter int unsigned CLEAR_CYCLES = 8,
   parameter int unsigned CW           = 8
) (
   input logic                    clk,
   input logic                    rst,
   fire_alarm_siren_ctrl_if.slave bus
);

   // --------------------------------------------------------------------------
   // Parameter sanity: every phase lasts at least one cycle and every count
   // fits in CW bits without wrapping.
   // --------------------------------------------------------------------------
   localparam int unsigned MAX_COUNT =
      (BEEP_ON > BEEP_OFF ? BEEP_ON : BEEP_OFF) > (HUSH_CYCLES > CLEAR_CYCLES ? HUSH_CYCLES : CLEAR_CYCLES)
      ? (BEEP_ON > BEEP_OFF ? BEEP_ON : BEEP_OFF)
      : (HUSH_CYCLES > CLEAR_CYCLES ? HUSH_CYCLES : CLEAR_CYCLES);

   generate
      if (BEEP_ON < 1 || BEEP_OFF < 1 || HUSH_CYCLES < 1 || CLEAR_CYCLES < 1) begin : g_bad_phase
         $error("fire_alarm_siren_ctrl: all phase lengths must be at least 1");
      end
      if (CW < 1 || CW > 31 || (2 ** CW) <= MAX_COUNT) begin : g_bad_width
         $error("fire_alarm_siren_ctrl: CW too narrow for the configured phase lengths");
      end
   endgenerate

   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] BEEP_ON_C  = CW'(BEEP_ON);
   localparam logic [CW-1:0] BEEP_OFF_C = CW'(BEEP_OFF);
   localparam logic [CW-1:0] HUSH_C     = CW'(HUSH_CYCLES);
   localparam logic [CW-1:0] CLEAR_C    = CW'(CLEAR_CYCLES);

   // --------------------------------------------------------------------------
   // State encoding matches the externally visible state code.
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ALARM      = 2'd1,
      HUSH       = 2'd2,
      CLEAR_WAIT = 2'd3
   } state_t;

   // Complete register image. The counters hold the number of cycles already
   // spent in the current phase, counting the entry cycle as 1; a value of 0
   // means the counter is idle.
   typedef struct packed {
      state_t        state;
      logic          siren;
      logic          strobe;
      logic          latched;
      logic          hush;
      logic          beep_on;    // 1: siren-on phase of the beep, 0: off phase
      logic [CW-1:0] beep_cnt;
      logic [CW-1:0] hush_cnt;
      logic [CW-1:0] clear_cnt;
   } regs_t;

   regs_t r;
   logic  silence_q;
   logic  silence_rise;

   // A held button produces exactly one rise; silence_q tracks the level every
   // cycle regardless of state, so a press in a state that ignores it is
   // consumed there and cannot fire later.
   assign silence_rise = bus.silence & ~silence_q;

   // --------------------------------------------------------------------------
   // Next-image builders for each state entry. Entering a state always starts
   // its counters afresh, which gives the "beep restarts at the on phase" and
   // "hush counter never reloads" behaviour by construction.
   // --------------------------------------------------------------------------
   function automatic regs_t enter_idle(input logic test_in);
      regs_t n;
      n       = '0;
      n.state = IDLE;
      n.siren = test_in;   // self-test drives the siren only while idle
      return n;
   endfunction

   function automatic regs_t enter_alarm();
      regs_t n;
      n          = '0;
      n.state    = ALARM;
      n.siren    = 1'b1;
      n.strobe   = 1'b1;
      n.latched  = 1'b1;
      n.beep_on  = 1'b1;
      n.beep_cnt = ONE;
      return n;
   endfunction

   function automatic regs_t enter_hush();
      regs_t n;
      n          = '0;
      n.state    = HUSH;
      n.strobe   = 1'b1;
      n.latched  = 1'b1;
      n.hush     = 1'b1;
      n.hush_cnt = ONE;
      return n;
   endfunction

   // The low sample that causes entry already counts as low sample #1, so a
   // single-sample clear interval goes straight back to idle.
   function automatic regs_t enter_clear(input logic test_in);
      regs_t n;
      if (CLEAR_CYCLES <= 1) begin
         n = enter_idle(test_in);
      end else begin
         n           = '0;
         n.state     = CLEAR_WAIT;
         n.strobe    = 1'b1;
         n.latched   = 1'b1;
         n.clear_cnt = ONE;
      end
      return n;
   endfunction

   // One cycle of the beep pattern: BEEP_ON cycles high, BEEP_OFF cycles low,
   // back to back. The counter restarts at 1 on each phase change so it never
   // runs past the longer phase.
   function automatic regs_t beep_step(input regs_t c);
      regs_t n;
      n = c;
      if (c.beep_on) begin
         if (c.beep_cnt >= BEEP_ON_C) begin
            n.beep_on  = 1'b0;
            n.beep_cnt = ONE;
            n.siren    = 1'b0;
         end else begin
            n.beep_cnt = c.beep_cnt + ONE;
            n.siren    = 1'b1;
         end
      end else begin
         if (c.beep_cnt >= BEEP_OFF_C) begin
            n.beep_on  = 1'b1;
            n.beep_cnt = ONE;
            n.siren    = 1'b1;
         end else begin
            n.beep_cnt = c.beep_cnt + ONE;
            n.siren    = 1'b0;
         end
      end
      return n;
   endfunction

   // --------------------------------------------------------------------------
   // FSM with registered outputs.
   // NOTE: all state is updated with non-blocking assignments so every flop
   // samples the pre-edge value of every other flop, independent of statement
   // order; blocking assignments here would create order-dependent races.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r         <= '0;
         silence_q <= 1'b0;
      end else begin
         silence_q <= bus.silence;

         case (r.state)
            IDLE: begin
               if (bus.alarmEnable) r <= enter_alarm();
               else                 r <= enter_idle(bus.test);
            end

            ALARM: begin
               // A falling request wins over a simultaneous hush press: the
               // panel is already on its way to clearing.
               if (!bus.alarmEnable)  r <= enter_clear(bus.test);
               else if (silence_rise) r <= enter_hush();
               else                   r <= beep_step(r);
            end

            HUSH: begin
               // Hush runs its full length; presses and request changes during
               // it are deliberately ignored.
               if (r.hush_cnt >= HUSH_C) begin
                  if (bus.alarmEnable) r <= enter_alarm();
                  else                 r <= enter_clear(bus.test);
               end else begin
                  r.hush_cnt <= r.hush_cnt + ONE;
               end
            end

            CLEAR_WAIT: begin
               if (bus.alarmEnable)                  r <= enter_alarm();
               else if (r.clear_cnt >= CLEAR_C - ONE) r <= enter_idle(bus.test);
               else                                  r.clear_cnt <= r.clear_cnt + ONE;
            end

            default: r <= enter_idle(bus.test);
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs come straight from flops.
   // --------------------------------------------------------------------------
   assign bus.state         = r.state;
   assign bus.siren         = r.siren;
   assign bus.strobe        = r.strobe;
   assign bus.alarm_latched = r.latched;
   assign bus.hush_active   = r.hush;

endmodule : fire_alarm_siren_ctrl

// File: tb/tb_fire_alarm_siren_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fire_alarm_siren_ctrl
//
// Drives fire_alarm_siren_ctrl with a table of per-cycle vectors followed by
// hand-written hush and reset sequences. Each step pushes the expected output
// image {state, siren, strobe, alarm_latched, hush_active} to a queue, lets one
// clock edge pass, then pops it and compares it with the sampled outputs.
// -----------------------------------------------------------------------------
module tb_fire_alarm_siren_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fire_alarm_siren_ctrl_if bus ();

   fire_alarm_siren_ctrl #(
      .BEEP_ON      (4),
      .BEEP_OFF     (4),
      .HUSH_CYCLES  (32),
      .CLEAR_CYCLES (8),
      .CW           (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected output images {state[1:0], siren, strobe, alarm_latched, hush}
   localparam logic [5:0] O_IDLE   = 6'b00_0_0_0_0;
   localparam logic [5:0] O_IDLE_T = 6'b00_1_0_0_0;  // idle with self-test
   localparam logic [5:0] O_ON     = 6'b01_1_1_1_0;
   localparam logic [5:0] O_OFF    = 6'b01_0_1_1_0;
   localparam logic [5:0] O_HUSH   = 6'b10_0_1_1_1;
   localparam logic [5:0] O_CLR    = 6'b11_0_1_1_0;

   typedef struct packed {
      logic       rst;
      logic       ae;
      logic       sil;
      logic       tst;
      logic [5:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   task automatic add(input logic r, input logic a, input logic s, input logic t,
                      input logic [5:0] e);
      vecs.push_back(vec_t'{rst: r, ae: a, sil: s, tst: t, exp: e});
   endtask

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s {state,siren,strobe,latched,hush} got=%b required=%b",
                  name, got, req);
      end
   endtask

   // Drive one cycle of inputs, then compare the outputs after the edge.
   task automatic step(input string name, input logic r, input logic a,
                       input logic s, input logic t, input logic [5:0] e);
      logic [5:0] got;
      logic [5:0] req;
      rst             = r;
      bus.alarmEnable = a;
      bus.silence     = s;
      bus.test        = t;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = {bus.state, bus.siren, bus.strobe, bus.alarm_latched, bus.hush_active};
      req = exp_q.pop_front();
      check(name, got, req);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.alarmEnable = 1'b0;
      bus.silence     = 1'b0;
      bus.test        = 1'b0;
      #1;

      // ---- table: reset, beep pattern, test ignored, clear paths, self-test
      add(1, 0, 0, 0, O_IDLE);                          // reset
      add(0, 0, 0, 0, O_IDLE);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, O_ON);   // on phase
      for (int i = 0; i < 4; i++) add(0, 1, 0, 1, O_OFF);  // off phase, test ignored
      add(0, 1, 0, 1, O_ON);                            // pattern repeats
      add(0, 0, 1, 0, O_CLR);                           // drop wins over silence rise
      for (int i = 0; i < 6; i++) add(0, 0, 1, 0, O_CLR);  // low samples 2..7
      add(0, 0, 1, 0, O_IDLE);                          // low sample 8 -> idle
      for (int i = 0; i < 3; i++) add(0, 0, 0, 1, O_IDLE_T); // self-test in idle
      add(0, 0, 0, 0, O_IDLE);
      add(0, 1, 0, 0, O_ON);
      add(0, 1, 0, 0, O_ON);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, O_CLR);  // 5 low samples
      add(0, 1, 0, 0, O_ON);                            // re-alarm, on phase restarts
      add(0, 1, 0, 0, O_ON);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 0, O_CLR);
      add(0, 0, 0, 0, O_IDLE);

      foreach (vecs[i])
         step($sformatf("tbl%0d", i), vecs[i].rst, vecs[i].ae, vecs[i].sil,
              vecs[i].tst, vecs[i].exp);

      // ---- hush for exactly HUSH_CYCLES, then beep restarts at on phase
      step("hush_arm0", 0, 1, 0, 0, O_ON);
      step("hush_arm1", 0, 1, 0, 0, O_ON);
      step("hush_enter", 0, 1, 1, 0, O_HUSH);
      for (int i = 1; i <= 31; i++)
         step($sformatf("hush_cyc%0d", i), 0, !(i >= 10 && i <= 12), (i >= 5), 0, O_HUSH);
      step("hush_exp_on0", 0, 1, 1, 0, O_ON);
      for (int i = 1; i < 4; i++) step($sformatf("hush_exp_on%0d", i), 0, 1, 1, 0, O_ON);
      for (int i = 0; i < 4; i++) step($sformatf("held_off%0d", i), 0, 1, 1, 0, O_OFF);

      // ---- reset mid-hush with silence held, no spurious hush afterwards
      step("rehush_rel", 0, 1, 0, 0, O_ON);
      step("rehush_enter", 0, 1, 1, 0, O_HUSH);
      for (int i = 0; i < 3; i++) step($sformatf("rehush%0d", i), 0, 1, 1, 0, O_HUSH);
      step("rst_mid_hush", 1, 1, 1, 0, O_IDLE);
      step("post_rst_alarm", 0, 1, 1, 0, O_ON);
      for (int i = 0; i < 3; i++) step($sformatf("post_rst_on%0d", i), 0, 1, 1, 0, O_ON);
      for (int i = 0; i < 2; i++) step($sformatf("post_rst_off%0d", i), 0, 1, 1, 0, O_OFF);
      step("post_rst_release", 0, 1, 0, 0, O_OFF);
      step("post_rst_press", 0, 1, 1, 0, O_HUSH);

      // ---- hush expiring with the request low goes to clear wait
      for (int i = 1; i <= 31; i++)
         step($sformatf("hush2_cyc%0d", i), 0, 1, 1, 0, O_HUSH);
      step("hush2_exp_clr", 0, 0, 1, 0, O_CLR);
      for (int i = 0; i < 6; i++) step($sformatf("hush2_clr%0d", i), 0, 0, 1, 0, O_CLR);
      step("hush2_idle", 0, 0, 1, 0, O_IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fire_alarm_siren_ctrl
